// File: rtl/skid_reg_if.sv
// Valid/ready handshake bundle for the skid_reg stage boundary.
// The master side is the stage that drives data in and drains data out;
// the slave side is the skid register itself.
interface skid_reg_if #(
    parameter int WIDTH = 8
);
    // Upstream (producer to skid register)
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;

    // Downstream (skid register to consumer)
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_DATA;

    modport master (
        output IN_VALID,
        output IN_DATA,
        input  IN_READY,
        input  OUT_VALID,
        input  OUT_DATA,
        output OUT_READY
    );

    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        output IN_READY,
        output OUT_VALID,
        output OUT_DATA,
        input  OUT_READY
    );
endinterface

// File: rtl/skid_reg.sv
// Two-entry valid/ready skid buffer.
// The head entry sits in the main register and drives OUT_DATA directly.
// A second (skid) register catches the one word that may arrive in the
// cycle downstream stalls. IN_READY is decoded from state only, so
// OUT_READY never reaches the upstream logic combinationally.
// A wrapping counter tracks completed output transfers for debug.
module skid_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RN,
    skid_reg_if.slave        bus,
    output logic [CNT_W-1:0] XFER_CNT
);

    // EMPTY: nothing held; FULL: main only; SKID: main + skid.
    // 2'b11 is unused and recovers to EMPTY on the next edge.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_xfer;

    // Handshake flags come from the state register alone.
    always_comb begin
        bus.OUT_VALID = (state != EMPTY);
        bus.IN_READY  = (state != SKID);
        bus.OUT_DATA  = main_q;
        XFER_CNT      = cnt_q;
        out_xfer      = (state != EMPTY) && bus.OUT_READY;
    end

    // State, storage and transfer counter; reset clears everything at once.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (out_xfer) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            case (state)
                EMPTY: begin
                    // OUT_READY has nothing to act on here.
                    if (bus.IN_VALID) begin
                        main_q <= bus.IN_DATA;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (bus.IN_VALID && bus.OUT_READY) begin
                        // Head leaves while a new word replaces it.
                        main_q <= bus.IN_DATA;
                    end else if (bus.IN_VALID) begin
                        // Downstream stalled: park the new word in skid.
                        skid_q <= bus.IN_DATA;
                        state  <= SKID;
                    end else if (bus.OUT_READY) begin
                        // main keeps its stale value so OUT_DATA stays quiet.
                        state <= EMPTY;
                    end
                end
                SKID: begin
                    // IN_READY is low, so upstream data is ignored here.
                    if (bus.OUT_READY) begin
                        main_q <= skid_q;
                        state  <= FULL;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skid_reg.sv
// Directed and randomised bench for skid_reg: table of single-cycle vectors,
// hand-written reset/wrap sequences, and a queue reference for random traffic.
module tb_skid_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int NVEC  = 14;

    logic             CLK;
    logic             RN;
    logic [CNT_W-1:0] XFER_CNT;

    skid_reg_if #(.WIDTH(WIDTH)) bus ();

    skid_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .RN       (RN),
        .bus      (bus),
        .XFER_CNT (XFER_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             ov;
        logic             ir;
        logic [WIDTH-1:0] od;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        bus.IN_VALID  = iv;
        bus.IN_DATA   = d;
        bus.OUT_READY = ordy;
    endtask

    logic [WIDTH-1:0] q [$];
    logic [CNT_W-1:0] mcnt;
    logic             iv_r, or_r;
    logic [WIDTH-1:0] d_r;
    logic             stalled;
    logic [WIDTH-1:0] held;
    logic             in_x, out_x;

    initial begin
        // {in_valid, in_data, out_ready} -> outputs after the edge
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 8'd0};
        vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 8'd1};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 8'd2};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 8'd3};
        vecs[4]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 8'd3};
        vecs[5]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'hA5, 8'd3};
        vecs[6]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hA5, 8'd3};
        vecs[7]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h5A, 8'd4};
        vecs[8]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 8'd5};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd6};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 8'd6};
        vecs[11] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 8'd6};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 8'd6};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 8'd7};

        // Reset asserted with arbitrary inputs, checked before any edge.
        RN = 1'b0;
        drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        #2;
        chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_in_ready",  32'(bus.IN_READY),  32'd1);
        chk("rst_out_data",  32'(bus.OUT_DATA),  32'h00);
        chk("rst_xfer_cnt",  32'(XFER_CNT),      32'd0);
        drive(1'b0, 8'h00, 1'b0);
        #6;
        RN = 1'b1;

        // Streaming, stall/fill and drain vectors.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy);
            step();
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.OUT_VALID), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_in_ready", i),  32'(bus.IN_READY),  32'(vecs[i].ir));
            chk($sformatf("vec%0d_out_data", i),  32'(bus.OUT_DATA),  32'(vecs[i].od));
            chk($sformatf("vec%0d_xfer_cnt", i),  32'(XFER_CNT),      32'(vecs[i].cnt));
        end

        // Reset mid-operation while holding 0x01/0x02 in SKID.
        drive(1'b1, 8'h01, 1'b0);
        step();
        drive(1'b1, 8'h02, 1'b0);
        step();
        chk("skid_in_ready", 32'(bus.IN_READY), 32'd0);
        chk("skid_head",     32'(bus.OUT_DATA), 32'h01);
        #2;
        RN = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("midrst_in_ready",  32'(bus.IN_READY),  32'd1);
        chk("midrst_out_data",  32'(bus.OUT_DATA),  32'h00);
        chk("midrst_xfer_cnt",  32'(XFER_CNT),      32'd0);
        #1;
        RN = 1'b1;
        drive(1'b1, 8'h77, 1'b1);
        step();
        chk("postrst_head", 32'(bus.OUT_DATA), 32'h77);
        drive(1'b0, 8'h00, 1'b1);
        step();
        chk("postrst_drained", 32'(bus.OUT_VALID), 32'd0);
        chk("postrst_cnt",     32'(XFER_CNT),      32'd1);

        // Counter wrap: clean reset, then 257 output transfers.
        #2;
        RN = 1'b0;
        #1;
        RN = 1'b1;
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 8'(i), 1'b1);
            step();
        end
        chk("wrap_at_256", 32'(XFER_CNT), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        step();
        chk("wrap_at_257", 32'(XFER_CNT), 32'd1);
        chk("wrap_empty",  32'(bus.OUT_VALID), 32'd0);

        // Random traffic against a reference queue.
        #2;
        RN = 1'b0;
        #1;
        RN = 1'b1;
        q.delete();
        mcnt    = '0;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 10000; c++) begin
            iv_r = 1'($urandom_range(0, 1));
            or_r = 1'($urandom_range(0, 3) != 0);
            d_r  = 8'($urandom_range(0, 255));
            drive(iv_r, d_r, or_r);
            in_x  = iv_r && (q.size() < 2);
            out_x = (q.size() > 0) && or_r;
            stalled = (q.size() > 0) && !or_r;
            if (stalled) held = q[0];
            step();
            if (out_x) begin
                void'(q.pop_front());
                mcnt = mcnt + 1'b1;
            end
            if (in_x) q.push_back(d_r);
            if (bus.OUT_VALID !== (q.size() > 0) || bus.IN_READY !== (q.size() < 2) || XFER_CNT !== mcnt) begin
                chk("rand_valid", 32'(bus.OUT_VALID), 32'(q.size() > 0));
                chk("rand_ready", 32'(bus.IN_READY),  32'(q.size() < 2));
                chk("rand_cnt",   32'(XFER_CNT),      32'(mcnt));
            end else begin
                checks++;
            end
            if (q.size() > 0) begin
                chk("rand_data", 32'(bus.OUT_DATA), 32'(q[0]));
            end
            if (stalled) begin
                chk("rand_stall_stable", 32'(bus.OUT_DATA), 32'(held));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
